// File: rtl/pwm_cfg_arbiter.sv
// Round-robin AXI4 write master sharing the axi_pwm register port among NUM_REQ requesters.
// One single-beat write is outstanding at a time; the response is reported back to the granted requester.
module pwm_cfg_arbiter #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int NUM_REQ        = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_done,
    output logic [NUM_REQ-1:0]                req_err,
    output logic [AXI_ID_WIDTH-1:0]           m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]           m_axi_bid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic                              busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W-1:0]   pick_s;
    logic               pick_vld_s;
    logic               aw_done_s;
    logic               w_done_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [NUM_REQ-1:0] req_done_s;
    logic [NUM_REQ-1:0] req_err_s;
    logic               unused_bid_s;

    // Round-robin search starting just after the last granted index, wrapping modulo NUM_REQ.
    always_comb begin
        cand_s     = '0;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (int'(last_q) + i >= NUM_REQ) begin
                cand_s = IDX_W'(int'(last_q) + i - NUM_REQ);
            end else begin
                cand_s = IDX_W'(int'(last_q) + i);
            end
            if (!pick_vld_s && req_valid[cand_s]) begin
                pick_s     = cand_s;
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Next-state, channel valids and requester pulses; last_q doubles as the current grant index.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        req_ready_s = '0;
        req_done_s  = '0;
        req_err_s   = '0;
        aw_done_s   = !awvalid_q || m_axi_awready;
        w_done_s    = !wvalid_q || m_axi_wready;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    req_ready_s[pick_s] = 1'b1;
                    last_d              = pick_s;
                    awaddr_d            = req_addr[int'(pick_s)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    wdata_d             = req_data[int'(pick_s)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                    awvalid_d           = 1'b1;
                    wvalid_d            = 1'b1;
                    state_d             = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                awvalid_d = awvalid_q && !m_axi_awready;
                wvalid_d  = wvalid_q && !m_axi_wready;
                if (aw_done_s && w_done_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp == 2'b00) begin
                        req_done_s[last_q] = 1'b1;
                    end else begin
                        req_err_s[last_q] = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
    end

    // State and captured transaction registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign req_ready     = req_ready_s;
    assign req_done      = req_done_s;
    assign req_err       = req_err_s;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == ST_RESP);
    assign busy          = (state_q != ST_IDLE);
    assign unused_bid_s  = ^m_axi_bid;

endmodule

// File: doc/pwm_cfg_arbiter.md
Name: pwm_cfg_arbiter

Overview:
- AXI write master that shares the axi_pwm slave register port between NUM_REQ local requesters. Typical requesters: motor loops, soft-start sequencer, CPU bridge.
- Each requester presents a register address and a data word. The block arbitrates round-robin and issues exactly one AXI write burst of length 1.
- It waits for the write response, then reports done or error back to the granted requester.
- Sits between control logic and the s_axi_aw/w/b ports of axi_pwm. It never reads.

Parameters:
- AXI_ID_WIDTH, 1, width of awid/bid.
- AXI_DATA_WIDTH, 32, width of write data.
- AXI_ADDR_WIDTH, 8, width of write address.
- NUM_REQ, 4, number of requesters (≥2).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  packed byte addresses; requester i at slice i.
- req_data  in  NUM_REQ*AXI_DATA_WIDTH  packed write data; requester i at slice i.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- req_done  out  NUM_REQ  one-hot, one-cycle pulse on OKAY response.
- req_err  out  NUM_REQ  one-hot, one-cycle pulse on non-OKAY response.
- m_axi_awid  out  AXI_ID_WIDTH  constant 0.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  captured address.
- m_axi_awprot  out  3  constant 0.
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  AXI_DATA_WIDTH  captured data.
- m_axi_wstrb  out  AXI_DATA_WIDTH/8  all ones.
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  AXI_ID_WIDTH  ignored.
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State = IDLE.
  - awvalid, wvalid, bready, busy, req_ready, req_done, req_err = 0.
  - awaddr and wdata = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req_valid, grant g = first index with req_valid set, searching from last+1 upward and wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from registered state and req_valid). Capture req_addr[g] and req_data[g]. Set last=g. Go to WRITE.
  - Requesters must hold valid, addr and data stable until ready. Dropping valid before grant is legal and loses the request.
- State WRITE:
  - awvalid and wvalid both assert on entry, on the cycle after grant.
  - Each deasserts independently on the cycle after its own handshake (valid & ready high at a clock edge).
  - awaddr and wdata stay stable while their valid is high.
  - Either order or simultaneous handshakes are legal.
  - Move to RESP once both channels have completed; this can happen in the same cycle as the last handshake.
- State RESP:
  - bready=1.
  - On bvalid & bready:
    - bresp==0: pulse req_done[g] for that one cycle.
    - bresp!=0: pulse req_err[g] instead.
    - Go to IDLE.
- Only one transaction is outstanding at a time. No new grant is issued before the response is consumed.
- Latency with a zero-wait slave: grant at cycle 0, AW/W handshake at cycle 1, B at cycle 2 at the earliest, done pulse in the same cycle as the B handshake. The next grant can occur in the cycle after that.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 transactions.
- A requester whose done/err pulse is active may present a new request in that same cycle. It is considered on the next IDLE cycle with lowest priority.
- Reset asserted mid-transaction:
  - All valids drop immediately.
  - The pending transaction is abandoned with no done or err pulse.
  - Slave reset is shared with this block.
- A bvalid arriving outside RESP is never accepted, because bready stays 0.

Test Plan:
- Single write: req_valid[2]=1, addr 0x0C, data 250, zero-wait slave -> req_ready[2] cycle 0; awaddr=0x0C and wdata=250 with awvalid and wvalid at cycle 1; req_done[2] at cycle 2; busy 1 across cycles 1–2.
- Round-robin: all four valid continuously, addresses 0x00/0x04/0x08/0x0C -> grant order 0,1,2,3,0, no requester granted twice before all others.
- Skewed handshake: awready held low 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds with stable awaddr, RESP entered only after the AW handshake; exactly one done pulse.
- Error response: bresp=2'b10 for requester 1 -> req_err[1] pulses once, req_done stays 0, next grant proceeds normally.
- Backpressured B: bvalid delayed 5 cycles -> no new req_ready during the wait; grant resumes the cycle after the B handshake.
- Reset mid-WRITE: aresetn low while awvalid=1 -> awvalid, wvalid, busy drop asynchronously; after release requester 0 has priority; no stale done pulse.
